// File: rtl/load_store_unit_pkg.sv
// Shared constants and types for the load/store unit: RV32I width codes,
// the access FSM states and the request legality check.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // A request is rejected before touching the bus when its width code is not
  // legal for its direction or the address is not naturally aligned.
  function automatic logic lsu_bad_request(input logic       is_store,
                                           input logic [2:0] funct3,
                                           input logic [1:0] byte_off);
    logic bad;
    bad = 1'b1;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = byte_off[0];
      F3_W:    bad = (byte_off != 2'b00);
      F3_BU:   bad = is_store;
      F3_HU:   bad = is_store | byte_off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_load_align_extend.sv
// Combinational load path: picks the addressed byte/half out of the read
// word and sign- or zero-extends it according to the width code.
module load_align_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection and extension of the returned word.
  always_comb begin
    byte_sel = rdata[7:0];
    case (byte_off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h000000, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0000, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one load or store per start over a req/ack bus,
// with byte-lane steering, alignment checks, a bus timeout and a busy stall.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_data,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           load_data,
  output logic                  err_misalign,
  output logic                  err_timeout,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;
  logic [31:0]           load_data_q, load_data_d;
  logic                  misalign_q, misalign_d;
  logic                  timeout_q, timeout_d;

  logic [31:0]           lane_wdata;
  logic [3:0]            lane_be;
  logic [31:0]           ext_data;

  load_align_extend u_align (
    .funct3   (funct3_q),
    .byte_off (off_q),
    .rdata    (mem_rdata),
    .result   (ext_data)
  );

  // Store lane replication and byte enables for the incoming request.
  always_comb begin
    lane_wdata = 32'h0;
    lane_be    = 4'b1111;
    if (is_store) begin
      case (funct3)
        F3_B: begin
          lane_wdata = {4{store_data[7:0]}};
          lane_be    = 4'b0001 << addr[1:0];
        end
        F3_H: begin
          lane_wdata = {2{store_data[15:0]}};
          lane_be    = addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          lane_wdata = store_data;
          lane_be    = 4'b1111;
        end
      endcase
    end
  end

  // Next-state logic: accept or reject in IDLE, wait for ack or timeout in REQ.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    load_data_d = load_data_q;
    misalign_d  = misalign_q;
    timeout_d   = timeout_q;
    case (state_q)
      LSU_IDLE: begin
        cnt_d = '0;
        if (start) begin
          timeout_d = 1'b0;
          if (lsu_bad_request(is_store, funct3, addr[1:0])) begin
            misalign_d = 1'b1;
            state_d    = LSU_DONE;
          end else begin
            misalign_d = 1'b0;
            we_d       = is_store;
            addr_d     = {addr[ADDR_WIDTH-1:2], 2'b00};
            wdata_d    = lane_wdata;
            be_d       = lane_be;
            funct3_d   = funct3;
            off_d      = addr[1:0];
            state_d    = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        if (mem_ack) begin
          if (!we_q) begin
            load_data_d = ext_data;
          end
          state_d = LSU_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = LSU_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LSU_DONE: begin
        cnt_d   = '0;
        state_d = LSU_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = LSU_IDLE;
      end
    endcase
  end

  // State and latched request registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LSU_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
      funct3_q    <= 3'h0;
      off_q       <= 2'h0;
      load_data_q <= 32'h0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      load_data_q <= load_data_d;
      misalign_q  <= misalign_d;
      timeout_q   <= timeout_d;
    end
  end

  assign busy         = (state_q != LSU_IDLE);
  assign done         = (state_q == LSU_DONE);
  assign mem_req      = (state_q == LSU_REQ);
  assign err_misalign = done & misalign_q;
  assign err_timeout  = done & timeout_q;
  assign load_data    = load_data_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_be       = be_q;

endmodule
